// File: rtl/apb4_slave_regbank_if.sv
// APB4 completer bus bundle: requester-driven address/control/data plus the completer response.
interface apb4_slave_regbank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_slave_regbank.sv
// APB4 byte-strobed register bank: read-only ID at word 0, programmable wait states,
// pslverr on out-of-range accesses and on writes to the ID word.
module apb4_slave_regbank #(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input logic                 pclk,
  input logic                 presetn,
  apb4_slave_regbank_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LANE_SHIFT = $clog2(STRB_WIDTH);
  localparam int IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_WIDTH-1:0] ID_WORD = DATA_WIDTH'(ID_VALUE);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_idx;
  logic [IW-1:0]         w_widx;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_resp;

  // Response data/error are computed from the bus when pready is registered,
  // so they are valid in the same cycle pready is seen high.
  always_comb begin
    w_idx  = bus.paddr >> LANE_SHIFT;
    w_widx = w_idx[IW-1:0];
    w_err  = (33'(w_idx) >= 33'(DEPTH)) || (bus.pwrite && (w_idx == '0));
    w_resp = '0;
    if (!bus.pwrite && !w_err) begin
      w_resp = (w_idx == '0) ? ID_WORD : r_mem[w_widx];
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[IW'(i)] <= '0;
      end
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      unique case (r_state)
        // DONE overlaps a possible back-to-back setup, so it decodes exactly like IDLE
        IDLE, DONE: begin
          r_state <= IDLE;
          if (bus.psel && !bus.penable) begin
            r_state <= ACCESS;
            r_cnt   <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_resp;
            end
          end
        end
        ACCESS: begin
          if (bus.psel && bus.penable) begin
            if (r_pready) begin
              if (bus.pwrite && !w_err) begin
                for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                  if (bus.pstrb[b]) begin
                    r_mem[w_widx][8*b +: 8] <= bus.pwdata[8*b +: 8];
                  end
                end
              end
              r_state <= DONE;
            end else if (r_cnt <= 4'd1) begin
              r_cnt     <= '0;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_resp;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.prdata  = r_prdata;
  assign bus.pready  = r_pready;
  assign bus.pslverr = r_pslverr;
endmodule

// File: doc/apb4_slave_regbank.md
Name: apb4_slave_regbank

Overview:
- Parameterised APB4 completer: a byte-strobed register bank with configurable wait states and error responses.
- Speaks the same pclk/presetn APB4 signal set as the team's UVM bench interface (paddr, psel, penable, pwrite, pwdata, pstrb, prdata, pready, pslverr).
- Serves as the next-generation DUT behind that bench.
- Adds over the fixed-behaviour slave:
  - width and depth generalisation
  - programmable wait states
  - pstrb byte lanes
  - a read-only ID word
  - pslverr on illegal accesses

Parameters:
- ADDR_WIDTH, 8: paddr width in bits; byte address.
- DATA_WIDTH, 32: data width; legal values 8, 16, 32, 64.
- STRB_WIDTH, DATA_WIDTH/8: byte strobes; derived, not overridden.
- DEPTH, 16: number of words; must satisfy DEPTH*STRB_WIDTH <= 2**ADDR_WIDTH.
- WAIT_CYCLES, 0: wait states inserted in each access phase before pready; range 0..15.
- ID_VALUE, 32'hA5B0_0001: constant returned by word 0, zero-extended or truncated to DATA_WIDTH.

Ports:
- pclk, input, 1: clock, rising edge.
- presetn, input, 1: asynchronous active-low reset.
- paddr, input, ADDR_WIDTH: byte address.
- psel, input, 1: slave select.
- penable, input, 1: access phase.
- pwrite, input, 1: 1 = write, 0 = read.
- pwdata, input, DATA_WIDTH: write data.
- pstrb, input, STRB_WIDTH: write byte enables.
- prdata, output, DATA_WIDTH: read data; registered.
- pready, output, 1: transfer complete; registered.
- pslverr, output, 1: error response; registered.

Behaviour:
- Reset (presetn=0, asynchronous, any cycle including mid-transfer):
  - prdata=0, pready=0, pslverr=0.
  - Wait counter=0; FSM=IDLE.
  - All words 1..DEPTH-1 = 0.
  - No partial write may survive.
- Decode:
  - idx = paddr >> log2(STRB_WIDTH); low address bits are ignored.
  - Error condition err = (idx >= DEPTH) | (pwrite & idx==0).
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On psel=1 & penable=0 (setup), load cnt=WAIT_CYCLES.
  - Go to ACCESS.
  - If WAIT_CYCLES=0, register pready=1 for the first access cycle.
- ACCESS: while psel & penable & cnt != 0, decrement cnt and keep pready=0.
  - When cnt reaches 0, pready is registered high for the next cycle.
  - Net timing: pready is high in access-phase cycle WAIT_CYCLES+1.
  - Total transfer length = WAIT_CYCLES+2 cycles including setup.
- Completion cycle (psel & penable & pready):
  - Write with !err: for each lane i with pstrb[i]=1, update mem[idx] byte i from pwdata byte i. Lanes with pstrb[i]=0 are unchanged. pstrb=0 is a legal no-op with pslverr=0.
  - Write with err: no storage change; pslverr=1.
  - Read with !err: prdata = mem[idx], or ID_VALUE for idx 0. The value is registered so it is valid in the same cycle pready is high. pstrb is ignored on reads.
  - Read with err: prdata=0, pslverr=1.
  - The next cycle clears pready, pslverr and prdata to 0, and the FSM goes to DONE then IDLE.
- Back-to-back transfers: a new setup is accepted in the cycle after completion. The DONE state lasts exactly one cycle and overlaps that setup cycle (DONE treats setup as IDLE would).
- pready, pslverr and prdata are 0 in every cycle other than a completion cycle.
- Abort (psel drops before pready): return to IDLE; no write; outputs cleared next cycle.
- Protocol errors:
  - penable=1 with the FSM in IDLE is ignored (no response).
  - Changes to paddr, pwrite or pwdata during the access phase: the slave samples them at completion only.

Test Plan:
- Reset readback, DEPTH=16, WAIT_CYCLES=0: read 0x00 -> prdata=0xA5B00001, pslverr=0; read 0x3C -> prdata=0, pready high in 2nd cycle of transfer.
- Full write then readback: write 0x08 = 0xDEADBEEF, pstrb=4'hF, then read 0x08 -> 0xDEADBEEF. Strobed write 0x08 = 0x11223344, pstrb=4'b0101 -> readback 0xDE22BE44.
- Error responses: write 0x00 -> pslverr=1 and ID is unchanged. Read 0x40 (idx 16) -> pslverr=1, prdata=0. Write 0x44 -> pslverr=1 and no word changes.
- Wait states, WAIT_CYCLES=3: pready=0 for 3 access cycles, high on the 4th; total transfer 5 cycles. Back-to-back writes to 0x04 and 0x0C complete at cycles 5 and 10.
- Reset mid-operation: assert presetn=0 during the 2nd wait cycle of a write 0x10 = 0xCAFEF00D -> outputs drop to 0 immediately; after release, read 0x10 -> 0.
- Abort: drop psel in the 1st access cycle with WAIT_CYCLES=2 -> pready never asserts; a subsequent read of the target word returns its old value.
